ahb_multi_mode_arbiter: RTL and testbench

Parametrised next-generation AHB slave-side arbiter: selects one of MASTER_NUM requesting masters per slave port, using fixed-priority, round-robin or weighted round-robin arbitration chosen at elaboration. It tracks every burst type, including undefined-length INCR, early termination and locked transfers, and hands ownership over only at transaction boundaries. It sits in the interconnect between the master request lines and the slave mux, one instance per slave.

---
 rtl/ahb_multi_mode_arbiter.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_ahb_multi_mode_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_multi_mode_arbiter.sv
// ---------------------------------------------------------------------------
// ahb_multi_mode_arbiter
//
// AHB slave-side arbiter. One instance per slave port. It picks one of
// MASTER_NUM requesting masters and holds the grant until the owner's
// transaction ends. Fixed bursts end on their last beat. Undefined-length INCR
// ends when the owner drops hreq, or after MAX_HOLD beats while another master
// waits. An IDLE after at least one beat also ends the transaction early.
// Arbitration is fixed priority, round robin or weighted round robin, chosen
// by ARB_MODE at elaboration.
//
// Ports
//   hclk, hreset_n  clock and asynchronous active-low reset
//   hreq, hlock     per-master request and locked-transfer request
//   hweight         per-master weight, WEIGHT_BIT each, master 0 in the LSBs
//   htrans, hburst  transfer type and burst type of the current owner
//   hwait           slave wait; a beat is accepted when hsel & ~hwait & htrans[1]
//   hgrant          registered one-hot grant
//   hsel            |hgrant
//   hmaster         index of the granted master (0 when none)
//   hlast           combinational; high on the accepted last beat
// ---------------------------------------------------------------------------
module ahb_multi_mode_arbiter #(
  parameter int MASTER_NUM = 4,
  parameter int ARB_MODE   = 1,
  parameter int WEIGHT_BIT = 4,
  parameter int MAX_HOLD   = 16
) (
  input  logic                             hclk,
  input  logic                             hreset_n,
  input  logic [MASTER_NUM-1:0]            hreq,
  input  logic [MASTER_NUM-1:0]            hlock,
  input  logic [MASTER_NUM*WEIGHT_BIT-1:0] hweight,
  input  logic [1:0]                       htrans,
  input  logic [2:0]                       hburst,
  input  logic                             hwait,
  output logic [MASTER_NUM-1:0]            hgrant,
  output logic                             hsel,
  output logic [$clog2(MASTER_NUM)-1:0]    hmaster,
  output logic                             hlast
);

  localparam int MW = $clog2(MASTER_NUM);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;

  localparam logic [2:0] BURST_SINGLE = 3'd0;
  localparam logic [2:0] BURST_INCR   = 3'd1;
  localparam logic [2:0] BURST_WRAP4  = 3'd2;
  localparam logic [2:0] BURST_INCR4  = 3'd3;
  localparam logic [2:0] BURST_WRAP8  = 3'd4;
  localparam logic [2:0] BURST_INCR8  = 3'd5;
  localparam logic [2:0] BURST_WRAP16 = 3'd6;
  localparam logic [2:0] BURST_INCR16 = 3'd7;

  typedef enum logic {ST_IDLE, ST_OWNED} state_t;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t                  state_reg, state_next;
  logic [MASTER_NUM-1:0]   hgrant_reg, hgrant_next;
  logic [MW-1:0]           hmaster_reg, hmaster_next;
  logic [2:0]              burst_reg, burst_next;
  logic [7:0]              beat_cnt_reg, beat_cnt_next;
  logic                    started_reg, started_next;
  logic [MW-1:0]           last_owner_reg, last_owner_next;
  logic [WEIGHT_BIT-1:0]   credit_reg  [MASTER_NUM];
  logic [WEIGHT_BIT-1:0]   credit_next [MASTER_NUM];

  // -------------------------------------------------------------------------
  // Beat decode
  // -------------------------------------------------------------------------
  logic       grant_any;
  logic       is_nonseq;
  logic       acc;
  logic [2:0] cur_burst;
  logic [7:0] beat_num;
  logic [7:0] fixed_len;
  logic       owner_req;
  logic       others_req;
  logic       last_beat;
  logic       early_term;
  logic       noreq_release;
  logic       txn_end;
  logic       lock_hold;
  logic       release_own;
  logic       arb_en;
  logic       grant_fire;

  assign grant_any = |hgrant_reg;

  always_comb begin
    is_nonseq  = (htrans == TR_NONSEQ);
    acc        = grant_any & ~hwait & htrans[1];
    // The NONSEQ beat carries its own burst type and is always beat 1.
    cur_burst  = is_nonseq ? hburst : burst_reg;
    beat_num   = is_nonseq ? 8'd1 : beat_cnt_reg + 8'd1;
    owner_req  = hreq[hmaster_reg];
    others_req = |(hreq & ~hgrant_reg);
    case (cur_burst)
      BURST_SINGLE:               fixed_len = 8'd1;
      BURST_WRAP4, BURST_INCR4:   fixed_len = 8'd4;
      BURST_WRAP8, BURST_INCR8:   fixed_len = 8'd8;
      BURST_WRAP16, BURST_INCR16: fixed_len = 8'd16;
      default:                    fixed_len = 8'd0;
    endcase
    // A SEQ seen before any NONSEQ has no burst context and never ends anything.
    if (!(acc && (is_nonseq || started_reg))) begin
      last_beat = 1'b0;
    end else if (cur_burst == BURST_INCR) begin
      last_beat = ~owner_req | (others_req & (beat_num >= 8'(MAX_HOLD)));
    end else begin
      last_beat = (beat_num == fixed_len);
    end

    early_term    = (state_reg == ST_OWNED) & started_reg & ~hwait &
                    (htrans == TR_IDLE);
    // Owner walked away before issuing a beat; an accepted beat this cycle is
    // handled by last_beat instead so it counts as one transaction end.
    noreq_release = (state_reg == ST_OWNED) & ~started_reg & ~owner_req &
                    ~hwait & ~acc;
    txn_end       = last_beat | early_term;
    lock_hold     = txn_end & hlock[hmaster_reg];
    release_own   = (txn_end & ~lock_hold) | noreq_release;
    arb_en        = (state_reg == ST_IDLE) | release_own;
    grant_fire    = arb_en & (|hreq);
  end

  // -------------------------------------------------------------------------
  // Credits (weighted round robin)
  // -------------------------------------------------------------------------
  logic [MASTER_NUM-1:0] credit_nz;
  logic [MASTER_NUM-1:0] eff_nz;
  logic [WEIGHT_BIT-1:0] eff_credit [MASTER_NUM];
  logic                  need_reload;
  logic [MW-1:0]         win_idx;

  // Reload only when no current requester has credit left.
  assign need_reload = ~|(hreq & credit_nz);

  generate
    for (genvar gi = 0; gi < MASTER_NUM; gi++) begin : g_credit
      logic [WEIGHT_BIT-1:0] weight_raw;
      logic [WEIGHT_BIT-1:0] weight_eff;

      assign weight_raw      = hweight[gi*WEIGHT_BIT +: WEIGHT_BIT];
      // A zero weight would lock a master out forever; treat it as 1.
      assign weight_eff      = (weight_raw == '0) ? WEIGHT_BIT'(1) : weight_raw;
      assign credit_nz[gi]   = |credit_reg[gi];
      assign eff_credit[gi]  = need_reload ? weight_eff : credit_reg[gi];
      assign eff_nz[gi]      = |eff_credit[gi];

      always_comb begin
        credit_next[gi] = credit_reg[gi];
        if ((ARB_MODE == 2) && grant_fire) begin
          credit_next[gi] = eff_credit[gi];
          if (win_idx == MW'(gi)) begin
            credit_next[gi] = eff_credit[gi] - WEIGHT_BIT'(1);
          end
        end
      end

      always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
          credit_reg[gi] <= '0;
        end else begin
          credit_reg[gi] <= credit_next[gi];
        end
      end
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Winner search: circular scan starting after base. Fixed priority is the
  // same scan with base pinned to the last index so master 0 is first.
  // -------------------------------------------------------------------------
  logic [MASTER_NUM-1:0] eligible;
  logic [MW-1:0]         base;
  logic [MW:0]           cand_wide;
  logic                  win_found;
  logic [MASTER_NUM-1:0] win_onehot;

  always_comb begin
    eligible = (ARB_MODE == 2) ? (hreq & eff_nz) : hreq;
    if (ARB_MODE == 0) begin
      base = MW'(MASTER_NUM - 1);
    end else begin
      // A transaction ending now makes its owner the new last_owner this cycle.
      base = txn_end ? hmaster_reg : last_owner_reg;
    end
    win_found = 1'b0;
    win_idx   = '0;
    cand_wide = '0;
    for (int i = 0; i < MASTER_NUM; i++) begin
      cand_wide = {1'b0, base} + (MW+1)'(i + 1);
      if (cand_wide >= (MW+1)'(MASTER_NUM)) begin
        cand_wide = cand_wide - (MW+1)'(MASTER_NUM);
      end
      if (!win_found && eligible[cand_wide[MW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand_wide[MW-1:0];
      end
    end
    win_onehot = {{(MASTER_NUM-1){1'b0}}, 1'b1} << win_idx;
  end

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state_reg      <= ST_IDLE;
      hgrant_reg     <= '0;
      hmaster_reg    <= '0;
      burst_reg      <= BURST_SINGLE;
      beat_cnt_reg   <= '0;
      started_reg    <= 1'b0;
      last_owner_reg <= MW'(MASTER_NUM - 1);
    end else begin
      state_reg      <= state_next;
      hgrant_reg     <= hgrant_next;
      hmaster_reg    <= hmaster_next;
      burst_reg      <= burst_next;
      beat_cnt_reg   <= beat_cnt_next;
      started_reg    <= started_next;
      last_owner_reg <= last_owner_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_next      = state_reg;
    hgrant_next     = hgrant_reg;
    hmaster_next    = hmaster_reg;
    burst_next      = burst_reg;
    beat_cnt_next   = beat_cnt_reg;
    started_next    = started_reg;
    last_owner_next = last_owner_reg;
    case (state_reg)
      ST_IDLE: begin
        if (grant_fire) begin
          state_next    = ST_OWNED;
          hgrant_next   = win_onehot;
          hmaster_next  = win_idx;
          beat_cnt_next = '0;
          started_next  = 1'b0;
        end
      end
      ST_OWNED: begin
        if (lock_hold) begin
          // Locked: same owner starts a fresh transaction, pointers untouched.
          beat_cnt_next = '0;
          started_next  = 1'b0;
        end else if (release_own) begin
          if (txn_end) begin
            last_owner_next = hmaster_reg;
          end
          beat_cnt_next = '0;
          started_next  = 1'b0;
          if (grant_fire) begin
            hgrant_next  = win_onehot;
            hmaster_next = win_idx;
          end else begin
            state_next   = ST_IDLE;
            hgrant_next  = '0;
            hmaster_next = '0;
          end
        end else if (acc) begin
          if (is_nonseq) begin
            burst_next    = hburst;
            beat_cnt_next = 8'd1;
            started_next  = 1'b1;
          end else if (started_reg && (beat_cnt_reg != 8'hFF)) begin
            beat_cnt_next = beat_cnt_reg + 8'd1;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    hgrant  = hgrant_reg;
    hsel    = grant_any;
    hmaster = hmaster_reg;
    hlast   = last_beat;
  end

endmodule

// File: tb/tb_ahb_multi_mode_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ahb_multi_mode_arbiter
//
// Three arbiter instances (fixed priority, round robin with MAX_HOLD=4,
// weighted round robin) share one set of stimulus signals; dut_sel picks the
// instance whose outputs are checked. Each driven cycle pushes its expected
// grant/hlast to a queue; a negedge monitor pops and compares.
// ---------------------------------------------------------------------------
module tb_ahb_multi_mode_arbiter;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  localparam logic [2:0] B_SINGLE = 3'd0;
  localparam logic [2:0] B_INCR   = 3'd1;
  localparam logic [2:0] B_INCR4  = 3'd3;
  localparam logic [2:0] B_WRAP8  = 3'd4;
  localparam logic [2:0] B_INCR8  = 3'd5;

  logic        hclk;
  logic        hreset_n;
  logic [3:0]  hreq;
  logic [3:0]  hlock;
  logic [15:0] hweight;
  logic [1:0]  htrans;
  logic [2:0]  hburst;
  logic        hwait;

  logic [3:0] fp_grant, rr_grant, wrr_grant;
  logic       fp_sel, rr_sel, wrr_sel;
  logic [1:0] fp_master, rr_master, wrr_master;
  logic       fp_last, rr_last, wrr_last;

  ahb_multi_mode_arbiter #(.MASTER_NUM(4), .ARB_MODE(0), .WEIGHT_BIT(4), .MAX_HOLD(16)) u_fp (
    .hclk(hclk), .hreset_n(hreset_n), .hreq(hreq), .hlock(hlock), .hweight(hweight),
    .htrans(htrans), .hburst(hburst), .hwait(hwait),
    .hgrant(fp_grant), .hsel(fp_sel), .hmaster(fp_master), .hlast(fp_last)
  );

  ahb_multi_mode_arbiter #(.MASTER_NUM(4), .ARB_MODE(1), .WEIGHT_BIT(4), .MAX_HOLD(4)) u_rr (
    .hclk(hclk), .hreset_n(hreset_n), .hreq(hreq), .hlock(hlock), .hweight(hweight),
    .htrans(htrans), .hburst(hburst), .hwait(hwait),
    .hgrant(rr_grant), .hsel(rr_sel), .hmaster(rr_master), .hlast(rr_last)
  );

  ahb_multi_mode_arbiter #(.MASTER_NUM(4), .ARB_MODE(2), .WEIGHT_BIT(4), .MAX_HOLD(16)) u_wrr (
    .hclk(hclk), .hreset_n(hreset_n), .hreq(hreq), .hlock(hlock), .hweight(hweight),
    .htrans(htrans), .hburst(hburst), .hwait(hwait),
    .hgrant(wrr_grant), .hsel(wrr_sel), .hmaster(wrr_master), .hlast(wrr_last)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  // Output mux for the instance under test
  int         dut_sel;
  logic [3:0] mon_grant;
  logic       mon_sel;
  logic [1:0] mon_master;
  logic       mon_last;

  always_comb begin
    mon_grant  = fp_grant;
    mon_sel    = fp_sel;
    mon_master = fp_master;
    mon_last   = fp_last;
    if (dut_sel == 1) begin
      mon_grant  = rr_grant;
      mon_sel    = rr_sel;
      mon_master = rr_master;
      mon_last   = rr_last;
    end else if (dut_sel == 2) begin
      mon_grant  = wrr_grant;
      mon_sel    = wrr_sel;
      mon_master = wrr_master;
      mon_last   = wrr_last;
    end
  end

  // Checking
  int checks;
  int errors;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] onehot_idx(input logic [3:0] g);
    logic [31:0] r;
    r = 32'd0;
    for (int i = 0; i < 4; i++) begin
      if (g[i]) r = 32'(i);
    end
    return r;
  endfunction

  // Scoreboard
  typedef struct {
    string      tag;
    logic [3:0] grant;
    logic       last;
  } exp_t;

  exp_t sb_q[$];

  always @(negedge hclk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      $display("%-12s req=%b trans=%0d grant=%b master=%0d last=%b", e.tag, hreq, htrans,
               mon_grant, mon_master, mon_last);
      check_eq({e.tag, "_grant"},  32'(mon_grant),  32'(e.grant));
      check_eq({e.tag, "_master"}, 32'(mon_master), onehot_idx(e.grant));
      check_eq({e.tag, "_sel"},    32'(mon_sel),    32'(|e.grant));
      check_eq({e.tag, "_last"},   32'(mon_last),   32'(e.last));
    end
  end

  task automatic drive(input logic [3:0] req, input logic [3:0] lock, input logic [1:0] trans,
                       input logic [2:0] burst, input logic wt,
                       input logic [3:0] exp_grant, input logic exp_last, input string tag);
    exp_t e;
    @(posedge hclk);
    #1;
    hreq   = req;
    hlock  = lock;
    htrans = trans;
    hburst = burst;
    hwait  = wt;
    e.tag   = tag;
    e.grant = exp_grant;
    e.last  = exp_last;
    sb_q.push_back(e);
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_rst_grant"},  32'(mon_grant),  32'd0);
    check_eq({tag, "_rst_sel"},    32'(mon_sel),    32'd0);
    check_eq({tag, "_rst_master"}, 32'(mon_master), 32'd0);
    check_eq({tag, "_rst_last"},   32'(mon_last),   32'd0);
  endtask

  task automatic do_reset(input int sel, input string tag);
    @(negedge hclk);
    #2;
    dut_sel  = sel;
    hreq     = '0;
    hlock    = '0;
    htrans   = TR_IDLE;
    hburst   = B_SINGLE;
    hwait    = 1'b0;
    hreset_n = 1'b0;
    #1;
    check_reset_state(tag);
    @(posedge hclk);
    @(posedge hclk);
    #2;
    hreset_n = 1'b1;
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  logic [3:0] rr_seq  [5];
  logic [3:0] wrr_seq [12];

  initial begin
    checks   = 0;
    errors   = 0;
    dut_sel  = 0;
    hreset_n = 1'b1;
    hreq     = '0;
    hlock    = '0;
    hweight  = {4'd3, 4'd1, 4'd1, 4'd1};
    htrans   = TR_IDLE;
    hburst   = B_SINGLE;
    hwait    = 1'b0;

    // ---- Round robin, all masters requesting SINGLE ----
    do_reset(1, "rr");
    rr_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    drive(4'b1111, 4'b0000, TR_IDLE, B_SINGLE, 1'b0, 4'b0000, 1'b0, "rr_arb");
    for (int k = 0; k < 5; k++) begin
      drive(4'b1111, 4'b0000, TR_NONSEQ, B_SINGLE, 1'b0, rr_seq[k], 1'b1, "rr_single");
    end
    drive(4'b0000, 4'b0000, TR_IDLE, B_SINGLE, 1'b0, 4'b0010, 1'b0, "rr_drop");
    drive(4'b0000, 4'b0000, TR_IDLE, B_SINGLE, 1'b0, 4'b0000, 1'b0, "rr_idle");

    // ---- Fixed priority, master 2 INCR8, master 0 joins at beat 3 ----
    do_reset(0, "fp");
    drive(4'b0100, 4'b0000, TR_IDLE,   B_INCR8, 1'b0, 4'b0000, 1'b0, "fp_arb");
    drive(4'b0100, 4'b0000, TR_NONSEQ, B_INCR8, 1'b0, 4'b0100, 1'b0, "fp_b1");
    drive(4'b0100, 4'b0000, TR_SEQ,    B_INCR8, 1'b0, 4'b0100, 1'b0, "fp_b2");
    for (int k = 3; k <= 7; k++) begin
      drive(4'b0101, 4'b0000, TR_SEQ, B_INCR8, 1'b0, 4'b0100, 1'b0, "fp_bmid");
    end
    drive(4'b0101, 4'b0000, TR_SEQ,    B_INCR8,  1'b0, 4'b0100, 1'b1, "fp_b8");
    drive(4'b0000, 4'b0000, TR_NONSEQ, B_SINGLE, 1'b0, 4'b0001, 1'b1, "fp_m0");
    drive(4'b0000, 4'b0000, TR_IDLE,   B_SINGLE, 1'b0, 4'b0000, 1'b0, "fp_idle");

    // ---- Weighted round robin, weights {3,1,1,1} ----
    do_reset(2, "wrr");
    wrr_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1000, 4'b1000,
                4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1000, 4'b1000};
    drive(4'b1111, 4'b0000, TR_IDLE, B_SINGLE, 1'b0, 4'b0000, 1'b0, "wrr_arb");
    for (int k = 0; k < 12; k++) begin
      drive(4'b1111, 4'b0000, TR_NONSEQ, B_SINGLE, 1'b0, wrr_seq[k], 1'b1, "wrr_single");
    end
    drive(4'b0000, 4'b0000, TR_IDLE, B_SINGLE, 1'b0, 4'b0001, 1'b0, "wrr_drop");
    drive(4'b0000, 4'b0000, TR_IDLE, B_SINGLE, 1'b0, 4'b0000, 1'b0, "wrr_idle");

    // ---- INCR capped at MAX_HOLD=4 with two wait states ----
    do_reset(1, "hold");
    drive(4'b0010, 4'b0000, TR_IDLE,   B_INCR,   1'b0, 4'b0000, 1'b0, "hold_arb");
    drive(4'b0110, 4'b0000, TR_NONSEQ, B_INCR,   1'b0, 4'b0010, 1'b0, "hold_b1");
    drive(4'b0110, 4'b0000, TR_SEQ,    B_INCR,   1'b1, 4'b0010, 1'b0, "hold_wait1");
    drive(4'b0110, 4'b0000, TR_SEQ,    B_INCR,   1'b0, 4'b0010, 1'b0, "hold_b2");
    drive(4'b0110, 4'b0000, TR_SEQ,    B_INCR,   1'b0, 4'b0010, 1'b0, "hold_b3");
    drive(4'b0110, 4'b0000, TR_SEQ,    B_INCR,   1'b1, 4'b0010, 1'b0, "hold_wait2");
    drive(4'b0110, 4'b0000, TR_SEQ,    B_INCR,   1'b0, 4'b0010, 1'b1, "hold_b4");
    drive(4'b0000, 4'b0000, TR_NONSEQ, B_SINGLE, 1'b0, 4'b0100, 1'b1, "hold_m2");
    drive(4'b0000, 4'b0000, TR_IDLE,   B_SINGLE, 1'b0, 4'b0000, 1'b0, "hold_idle");

    // ---- Locked INCR4 re-grant, then handover once the lock drops ----
    do_reset(1, "lock");
    drive(4'b0001, 4'b0001, TR_IDLE,   B_INCR4, 1'b0, 4'b0000, 1'b0, "lock_arb");
    drive(4'b0011, 4'b0001, TR_NONSEQ, B_INCR4, 1'b0, 4'b0001, 1'b0, "lock_b1");
    drive(4'b0011, 4'b0001, TR_SEQ,    B_INCR4, 1'b0, 4'b0001, 1'b0, "lock_b2");
    drive(4'b0011, 4'b0001, TR_SEQ,    B_INCR4, 1'b0, 4'b0001, 1'b0, "lock_b3");
    drive(4'b0011, 4'b0001, TR_SEQ,    B_INCR4, 1'b0, 4'b0001, 1'b1, "lock_b4");
    drive(4'b0011, 4'b0000, TR_NONSEQ, B_INCR4, 1'b0, 4'b0001, 1'b0, "unlk_b1");
    drive(4'b0011, 4'b0000, TR_SEQ,    B_INCR4, 1'b0, 4'b0001, 1'b0, "unlk_b2");
    drive(4'b0011, 4'b0000, TR_SEQ,    B_INCR4, 1'b0, 4'b0001, 1'b0, "unlk_b3");
    drive(4'b0011, 4'b0000, TR_SEQ,    B_INCR4, 1'b0, 4'b0001, 1'b1, "unlk_b4");
    drive(4'b0000, 4'b0000, TR_NONSEQ, B_SINGLE, 1'b0, 4'b0010, 1'b1, "lock_m1");
    drive(4'b0000, 4'b0000, TR_IDLE,   B_SINGLE, 1'b0, 4'b0000, 1'b0, "lock_idle");

    // ---- Asynchronous reset during beat 5 of a WRAP8 ----
    do_reset(1, "wrap");
    drive(4'b0001, 4'b0000, TR_IDLE,   B_WRAP8, 1'b0, 4'b0000, 1'b0, "wrap_arb");
    drive(4'b0001, 4'b0000, TR_NONSEQ, B_WRAP8, 1'b0, 4'b0001, 1'b0, "wrap_b1");
    for (int k = 2; k <= 5; k++) begin
      drive(4'b0001, 4'b0000, TR_SEQ, B_WRAP8, 1'b0, 4'b0001, 1'b0, "wrap_bn");
    end
    @(negedge hclk);
    #2;
    hreset_n = 1'b0;
    #1;
    check_reset_state("wrap_async");
    @(posedge hclk);
    #2;
    hreq   = '0;
    htrans = TR_IDLE;
    @(posedge hclk);
    #2;
    hreset_n = 1'b1;
    drive(4'b1000, 4'b0000, TR_IDLE, B_SINGLE, 1'b0, 4'b0000, 1'b0, "post_arb");
    drive(4'b1000, 4'b0000, TR_IDLE, B_SINGLE, 1'b0, 4'b1000, 1'b0, "post_grant");
    drive(4'b0000, 4'b0000, TR_IDLE, B_SINGLE, 1'b0, 4'b1000, 1'b0, "post_drop");
    drive(4'b0000, 4'b0000, TR_IDLE, B_SINGLE, 1'b0, 4'b0000, 1'b0, "post_idle");

    @(negedge hclk);
    #1;
    check_eq("sb_drain", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
